// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM sequencing fetch, decode,
// operand read, execute and ALU write-back for an 8-bit core.
module control_unit #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter bit         ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [7:0] mem_addr,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic       alu_en,
  output logic [1:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic [7:0] reg_a,
  output logic [7:0] reg_b,
  output logic [7:0] pc,
  output logic       flag_z,
  output logic       flag_c,
  output logic       halted,
  output logic       illegal
);

  localparam logic [7:0] OP_STORE = 8'h01;
  localparam logic [7:0] OP_LOAD  = 8'h02;
  localparam logic [7:0] OP_STOP  = 8'h04;
  localparam logic [7:0] OP_JUMP  = 8'h08;
  localparam logic [7:0] OP_MST   = 8'h10;
  localparam logic [7:0] OP_INC   = 8'h20;
  localparam logic [7:0] OP_DEC   = 8'h40;
  localparam logic [7:0] OP_ADD   = 8'h80;
  localparam logic [7:0] OP_SUB   = 8'h81;
  localparam logic [7:0] OP_SWAP  = 8'h83;

  localparam logic [1:0] ALU_ONE = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  typedef enum logic [2:0] {
    FETCH, DECODE, OPERAND, EXEC, WB, HALT
  } state_t;

  state_t     state, state_nx;
  logic [7:0] pc_q, pc_nx;
  logic [7:0] a_q, a_nx;
  logic [7:0] b_q, b_nx;
  logic [7:0] ir_q, ir_nx;
  logic [7:0] opr_q, opr_nx;
  logic       z_q, z_nx;
  logic       c_q, c_nx;
  logic       ill_q, ill_nx;
  logic       two_byte;

  assign two_byte = (mem_rdata == OP_LOAD) ||
                    (mem_rdata == OP_JUMP) ||
                    (mem_rdata == OP_MST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc_q  <= RESET_PC;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      ir_q  <= 8'h00;
      opr_q <= 8'h00;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      ir_q  <= ir_nx;
      opr_q <= opr_nx;
      z_q   <= z_nx;
      c_q   <= c_nx;
      ill_q <= ill_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc_q;
    a_nx      = a_q;
    b_nx      = b_q;
    ir_nx     = ir_q;
    opr_nx    = opr_q;
    z_nx      = z_q;
    c_nx      = c_q;
    ill_nx    = ill_q;
    mem_addr  = pc_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = a_q;
    alu_en    = 1'b0;
    alu_op    = ALU_ONE;
    alu_a     = a_q;
    alu_b     = b_q;
    if (!hold) begin
      unique case (state)
        FETCH: begin
          mem_re   = 1'b1;
          state_nx = DECODE;
        end
        DECODE: begin
          ir_nx = mem_rdata;
          pc_nx = pc_q + 8'd1;
          if (two_byte) begin
            mem_re   = 1'b1;
            mem_addr = pc_q + 8'd1;
            state_nx = OPERAND;
          end else begin
            state_nx = EXEC;
          end
        end
        OPERAND: begin
          opr_nx   = mem_rdata;
          pc_nx    = pc_q + 8'd1;
          state_nx = EXEC;
        end
        EXEC: begin
          state_nx = FETCH;
          unique case (1'b1)
            ir_q == OP_STORE: b_nx = a_q;
            ir_q == OP_LOAD:  a_nx = opr_q;
            ir_q == OP_STOP:  state_nx = HALT;
            ir_q == OP_JUMP:  pc_nx = opr_q;
            ir_q == OP_MST: begin
              mem_we   = 1'b1;
              mem_addr = opr_q;
            end
            ir_q == OP_INC,
            ir_q == OP_DEC: begin
              alu_en   = 1'b1;
              alu_a    = ir_q;
              alu_b    = a_q;
              state_nx = WB;
            end
            ir_q == OP_ADD: begin
              alu_en   = 1'b1;
              alu_op   = ALU_ADD;
              state_nx = WB;
            end
            ir_q == OP_SUB: begin
              alu_en   = 1'b1;
              alu_op   = ALU_SUB;
              state_nx = WB;
            end
            ir_q == OP_SWAP: begin
              a_nx = b_q;
              b_nx = a_q;
            end
            default: begin
              if (ILLEGAL_HALT) begin
                ill_nx   = 1'b1;
                state_nx = HALT;
              end
            end
          endcase
        end
        WB: begin
          a_nx     = alu_out;
          z_nx     = alu_zero;
          c_nx     = alu_carry;
          state_nx = FETCH;
        end
        HALT: state_nx = HALT;
        default: state_nx = FETCH;
      endcase
    end
    // strobes stay quiet for the whole reset pulse
    if (rst) begin
      mem_re = 1'b0;
      mem_we = 1'b0;
      alu_en = 1'b0;
    end
  end

  assign reg_a   = a_q;
  assign reg_b   = b_q;
  assign pc      = pc_q;
  assign flag_z  = z_q;
  assign flag_c  = c_q;
  assign halted  = (state == HALT);
  assign illegal = ill_q;

endmodule
